// File: rtl/div_unit_gen2.sv
// Iterative restoring divider (STEPS quotient bits per cycle) for RV32M/RV64M DIV/DIVU/REM/REMU,
// with a valid/ready result handshake, a pipeline kill and a one-entry result cache.
module div_unit_gen2 #(
   parameter int XLEN  = 32,
   parameter int STEPS = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] OP1_SE,
   input  logic [XLEN-1:0] OP2_SE,
   input  logic [1:0]      CMD_RD,
   input  logic [5:0]      DEST_RD,
   input  logic            START_DIV,
   output logic            READY_DIV,
   input  logic            KILL_DIV,
   output logic            BUSY_DIV,
   output logic            DONE_DIV,
   input  logic            POP_DIV,
   output logic [XLEN-1:0] RES_DIV,
   output logic [5:0]      DEST_DIV
);

   localparam int ITER  = XLEN / STEPS;
   localparam int CNT_W = $clog2(ITER + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [5:0]      dest_q, dest_d;
   logic            s1_q, s1_d;
   logic            s2_q, s2_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] op1_q, op1_d;
   logic [XLEN-1:0] op2_q, op2_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            c_vld_q, c_vld_d;
   logic [XLEN-1:0] c_op1_q, c_op1_d;
   logic [XLEN-1:0] c_op2_q, c_op2_d;
   logic            c_uns_q, c_uns_d;
   logic [XLEN-1:0] c_quo_q, c_quo_d;
   logic [XLEN-1:0] c_rem_q, c_rem_d;

   logic            accept;
   logic            signed_req, op1_neg, op2_neg;
   logic [XLEN-1:0] op1_mag, op2_mag;
   logic            div_zero, ovf, hit, special;
   logic [XLEN-1:0] sp_quo, sp_rem;
   logic [XLEN:0]   st_rem;
   logic [XLEN-1:0] st_quo;
   logic [XLEN-1:0] fin_quo, fin_rem;

   // Handshake: a request is taken on an edge where START_DIV & READY_DIV & ~KILL_DIV;
   // a result is held on RES_DIV/DEST_DIV while DONE_DIV=1 and retired on an edge with POP_DIV=1.
   assign READY_DIV = (state_q == S_IDLE) | ((state_q == S_DONE) & POP_DIV);
   assign accept    = START_DIV & READY_DIV & ~KILL_DIV;
   assign BUSY_DIV  = (state_q == S_BUSY);
   assign DONE_DIV  = (state_q == S_DONE);
   assign RES_DIV   = res_q;
   assign DEST_DIV  = dest_q;

   assign signed_req = ~CMD_RD[0];
   assign op1_neg    = signed_req & OP1_SE[XLEN-1];
   assign op2_neg    = signed_req & OP2_SE[XLEN-1];
   assign op1_mag    = op1_neg ? -OP1_SE : OP1_SE;
   assign op2_mag    = op2_neg ? -OP2_SE : OP2_SE;
   assign div_zero   = (OP2_SE == '0);
   assign ovf        = signed_req & (OP1_SE == {1'b1, {(XLEN-1){1'b0}}}) & (&OP2_SE);
   assign hit        = c_vld_q & (OP1_SE == c_op1_q) & (OP2_SE == c_op2_q) & (CMD_RD[0] == c_uns_q);
   assign special    = div_zero | ovf | hit;

   always_comb begin
      sp_quo = c_quo_q;
      sp_rem = c_rem_q;
      if (div_zero) begin
         sp_quo = '1;
         sp_rem = OP1_SE;
      end else if (ovf) begin
         sp_quo = OP1_SE;
         sp_rem = '0;
      end
   end

   // STEPS restoring steps per cycle; the dividend shifts out of quo_q as quotient bits shift in.
   always_comb begin
      st_rem = rem_q;
      st_quo = quo_q;
      for (int i = 0; i < STEPS; i++) begin
         st_rem = {st_rem[XLEN-1:0], st_quo[XLEN-1]};
         st_quo = {st_quo[XLEN-2:0], 1'b0};
         if (st_rem >= {1'b0, dvs_q}) begin
            st_rem    = st_rem - {1'b0, dvs_q};
            st_quo[0] = 1'b1;
         end
      end
   end

   assign fin_quo = (s1_q ^ s2_q) ? -st_quo : st_quo;
   assign fin_rem = s1_q ? -st_rem[XLEN-1:0] : st_rem[XLEN-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      dest_d  = dest_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      res_d   = res_q;
      c_vld_d = c_vld_q;
      c_op1_d = c_op1_q;
      c_op2_d = c_op2_q;
      c_uns_d = c_uns_q;
      c_quo_d = c_quo_q;
      c_rem_d = c_rem_q;
      if (KILL_DIV) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_BUSY: begin
               quo_d = st_quo;
               rem_d = st_rem;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_DONE;
                  res_d   = cmd_q[1] ? fin_rem : fin_quo;
                  c_vld_d = 1'b1;
                  c_op1_d = op1_q;
                  c_op2_d = op2_q;
                  c_uns_d = cmd_q[0];
                  c_quo_d = fin_quo;
                  c_rem_d = fin_rem;
               end
            end
            S_DONE: if (POP_DIV) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
         // A new request overrides the POP->IDLE move so back-to-back issue has no bubble.
         if (accept) begin
            cmd_d  = CMD_RD;
            dest_d = DEST_RD;
            s1_d   = op1_neg;
            s2_d   = op2_neg;
            op1_d  = OP1_SE;
            op2_d  = OP2_SE;
            if (special) begin
               state_d = S_DONE;
               cnt_d   = '0;
               res_d   = CMD_RD[1] ? sp_rem : sp_quo;
               c_vld_d = 1'b1;
               c_op1_d = OP1_SE;
               c_op2_d = OP2_SE;
               c_uns_d = CMD_RD[0];
               c_quo_d = sp_quo;
               c_rem_d = sp_rem;
            end else begin
               state_d = S_BUSY;
               cnt_d   = CNT_W'(ITER);
               quo_d   = op1_mag;
               rem_d   = '0;
               dvs_d   = op2_mag;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         dest_q  <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         res_q   <= '0;
         c_vld_q <= 1'b0;
         c_op1_q <= '0;
         c_op2_q <= '0;
         c_uns_q <= 1'b0;
         c_quo_q <= '0;
         c_rem_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         dest_q  <= dest_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         res_q   <= res_d;
         c_vld_q <= c_vld_d;
         c_op1_q <= c_op1_d;
         c_op2_q <= c_op2_d;
         c_uns_q <= c_uns_d;
         c_quo_q <= c_quo_d;
         c_rem_q <= c_rem_d;
      end
   end

endmodule

// File: tb/tb_div_unit_gen2.sv
// Bench for div_unit_gen2: a 32/1 and a 64/4 instance driven with directed vectors; per-instance
// monitors compare results, tags and DONE timing against queued expectations.
module tb_div_unit_gen2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   logic [31:0] a32 = '0, b32 = '0;
   logic [1:0]  cmd32 = '0;
   logic [5:0]  din32 = '0;
   logic        start32 = 1'b0, kill32 = 1'b0, pop32 = 1'b0;
   logic        rdy32, busy32, done32;
   logic [31:0] res32;
   logic [5:0]  dest32;

   logic [63:0] a64 = '0, b64 = '0;
   logic [1:0]  cmd64 = '0;
   logic [5:0]  din64 = '0;
   logic        start64 = 1'b0, kill64 = 1'b0, pop64 = 1'b0;
   logic        rdy64, busy64, done64;
   logic [63:0] res64;
   logic [5:0]  dest64;

   // {result, tag} expectations and the cycle on which DONE must first be seen
   logic [37:0] exp_q[$];
   int          due_q[$];
   logic [69:0] exp64_q[$];
   int          due64_q[$];
   logic        seen32 = 1'b0, seen64 = 1'b0;

   div_unit_gen2 #(.XLEN(32), .STEPS(1)) dut32 (
      .clk(clk), .reset(reset), .OP1_SE(a32), .OP2_SE(b32), .CMD_RD(cmd32), .DEST_RD(din32),
      .START_DIV(start32), .READY_DIV(rdy32), .KILL_DIV(kill32), .BUSY_DIV(busy32),
      .DONE_DIV(done32), .POP_DIV(pop32), .RES_DIV(res32), .DEST_DIV(dest32)
   );

   div_unit_gen2 #(.XLEN(64), .STEPS(4)) dut64 (
      .clk(clk), .reset(reset), .OP1_SE(a64), .OP2_SE(b64), .CMD_RD(cmd64), .DEST_RD(din64),
      .START_DIV(start64), .READY_DIV(rdy64), .KILL_DIV(kill64), .BUSY_DIV(busy64),
      .DONE_DIV(done64), .POP_DIV(pop64), .RES_DIV(res64), .DEST_DIV(dest64)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready32"}, 64'(rdy32), 64'd1);
      check({tag, "_busy32"}, 64'(busy32), 64'd0);
      check({tag, "_done32"}, 64'(done32), 64'd0);
      check({tag, "_res32"}, 64'(res32), 64'd0);
      check({tag, "_dest32"}, 64'(dest32), 64'd0);
      check({tag, "_ready64"}, 64'(rdy64), 64'd1);
      check({tag, "_busy64"}, 64'(busy64), 64'd0);
      check({tag, "_done64"}, 64'(done64), 64'd0);
      check({tag, "_res64"}, res64, 64'd0);
      check({tag, "_dest64"}, 64'(dest64), 64'd0);
   endtask

   // drivers: inputs change 1ns after a rising edge; lat = edges after the accept edge until DONE
   task automatic start_op(input bit sel, input logic [1:0] cmd, input logic [63:0] a, input logic [63:0] b,
                           input logic [5:0] dest, input logic [63:0] exp_res, input int lat, input bit push);
      bit ok = 1'b0;
      if (sel) begin
         a64 = a; b64 = b; cmd64 = cmd; din64 = dest; start64 = 1'b1;
      end else begin
         a32 = a[31:0]; b32 = b[31:0]; cmd32 = cmd; din32 = dest; start32 = 1'b1;
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sel ? rdy64 : rdy32) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      start32 = 1'b0;
      start64 = 1'b0;
      if (!ok) check("ready_timeout", 64'd0, 64'd1);
      else if (push) begin
         if (sel) begin
            exp64_q.push_back({exp_res, dest});
            due64_q.push_back(cyc + lat);
         end else begin
            exp_q.push_back({exp_res[31:0], dest});
            due_q.push_back(cyc + lat);
         end
      end
   endtask

   task automatic wait_done(input bit sel, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sel ? done64 : done32) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic pop_res(input bit sel);
      @(posedge clk);
      #1;
      if (sel) pop64 = 1'b1; else pop32 = 1'b1;
      @(posedge clk);
      #1;
      pop32 = 1'b0;
      pop64 = 1'b0;
   endtask

   task automatic run(input bit sel, input logic [1:0] cmd, input logic [63:0] a, input logic [63:0] b,
                      input logic [5:0] dest, input logic [63:0] exp_res, input int lat);
      start_op(sel, cmd, a, b, dest, exp_res, lat, 1'b1);
      wait_done(sel, 80);
      pop_res(sel);
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (reset) seen32 <= 1'b0;
      else if (done32) begin
         if (exp_q.size() == 0) check("spurious_done32", 64'(done32), 64'd0);
         else begin
            if (!seen32) check("latency32", 64'(cyc), 64'(due_q[0]));
            seen32 <= 1'b1;
            check("res32", 64'(res32), 64'(exp_q[0][37:6]));
            check("dest32", 64'(dest32), 64'(exp_q[0][5:0]));
            if (pop32 && !kill32) begin
               void'(exp_q.pop_front());
               void'(due_q.pop_front());
               seen32 <= 1'b0;
            end
         end
      end else seen32 <= 1'b0;
   end

   always @(negedge clk) begin
      if (reset) seen64 <= 1'b0;
      else if (done64) begin
         if (exp64_q.size() == 0) check("spurious_done64", 64'(done64), 64'd0);
         else begin
            if (!seen64) check("latency64", 64'(cyc), 64'(due64_q[0]));
            seen64 <= 1'b1;
            check("res64", res64, exp64_q[0][69:6]);
            check("dest64", 64'(dest64), 64'(exp64_q[0][5:0]));
            if (pop64 && !kill64) begin
               void'(exp64_q.pop_front());
               void'(due64_q.pop_front());
               seen64 <= 1'b0;
            end
         end
      end else seen64 <= 1'b0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus, expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_idle("reset");

      // signed divide, cache hit on REM, unsigned REMU misses the signed entry
      run(0, 2'b00, 64'd20, 64'hFFFF_FFFD, 6'd1, 64'hFFFF_FFFA, 32);
      run(0, 2'b10, 64'd20, 64'hFFFF_FFFD, 6'd2, 64'd2, 0);
      run(0, 2'b11, 64'd20, 64'hFFFF_FFFD, 6'd3, 64'd20, 32);
      // divide by zero and signed overflow
      run(0, 2'b01, 64'h1234_5678, 64'd0, 6'd4, 64'hFFFF_FFFF, 0);
      run(0, 2'b11, 64'h1234_5678, 64'd0, 6'd5, 64'h1234_5678, 0);
      run(0, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 6'd6, 64'h8000_0000, 0);
      run(0, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF, 6'd7, 64'd0, 0);
      // sign fix-ups and the unsigned form of the overflow operands
      run(0, 2'b00, 64'hFFFF_FF9C, 64'd7, 6'd8, 64'hFFFF_FFF2, 32);
      run(0, 2'b10, 64'hFFFF_FF9C, 64'd7, 6'd9, 64'hFFFF_FFFE, 0);
      run(0, 2'b00, 64'hFFFF_FF9C, 64'hFFFF_FFF9, 6'd10, 64'd14, 32);
      run(0, 2'b01, 64'h8000_0000, 64'hFFFF_FFFF, 6'd11, 64'd0, 32);

      // kill on the 10th busy cycle
      start_op(0, 2'b00, 64'd100, 64'd7, 6'd12, 64'd0, 0, 1'b0);
      @(negedge clk);
      check("busy_after_accept", 64'(busy32), 64'd1);
      check("ready_while_busy", 64'(rdy32), 64'd0);
      repeat (9) @(posedge clk);
      #1 kill32 = 1'b1;
      @(posedge clk);
      #1 kill32 = 1'b0;
      @(negedge clk);
      check("kill_busy", 64'(busy32), 64'd0);
      check("kill_done", 64'(done32), 64'd0);
      check("kill_ready", 64'(rdy32), 64'd1);
      repeat (40) @(posedge clk);
      #1;
      run(0, 2'b10, 64'd100, 64'd7, 6'd13, 64'd2, 32);
      run(0, 2'b00, 64'd100, 64'd7, 6'd14, 64'd14, 0);

      // late pop, a START ignored while busy, then POP+START back-to-back
      start_op(0, 2'b01, 64'd1000, 64'd10, 6'd15, 64'd100, 32, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      start32 = 1'b1; a32 = 32'd5; b32 = 32'd0; cmd32 = 2'b01; din32 = 6'd33;
      @(posedge clk);
      #1 start32 = 1'b0;
      wait_done(0, 80);
      repeat (5) @(posedge clk);
      #1 pop32 = 1'b1;
      start_op(0, 2'b01, 64'hFFFF_FFFF, 64'h0001_0000, 6'h2A, 64'h0000_FFFF, 32, 1'b1);
      pop32 = 1'b0;
      wait_done(0, 80);
      pop_res(0);

      // 64-bit, 4 bits per cycle
      run(1, 2'b01, 64'h8000_0000_0000_0000, 64'd3, 6'd16, 64'h2AAA_AAAA_AAAA_AAAA, 16);
      run(1, 2'b11, 64'h8000_0000_0000_0000, 64'd3, 6'd17, 64'd2, 0);
      run(1, 2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd18, 64'hFFFF_FFFF_FFFF_FFFD, 16);
      run(1, 2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd19, 64'hFFFF_FFFF_FFFF_FFFF, 0);

      // asynchronous reset mid-operation, then the cache must be empty
      start_op(0, 2'b00, 64'd100, 64'd7, 6'd20, 64'd0, 0, 1'b0);
      start_op(1, 2'b01, 64'd1000, 64'd3, 6'd21, 64'd0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1 check_idle("async_reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run(0, 2'b01, 64'hFFFF_FFFF, 64'h0001_0000, 6'd22, 64'h0000_FFFF, 32);
      run(1, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd23, 64'd1, 16);

      repeat (3) @(posedge clk);
      check("queue32_drained", 64'(exp_q.size()), 64'd0);
      check("queue64_drained", 64'(exp64_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
